vfd_scanout: RTL and testbench



---
 rtl/vfd_pkg.sv | 27 ++
 rtl/vfd_timing.sv | 62 ++++++
 rtl/vfd_scanout.sv | 150 +++++++++++++++
 tb/tb_vfd_scanout.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/vfd_pkg.sv
// vfd_pkg: shared raster timing defaults, screen geometry and RGB332 expansion
package vfd_pkg;
  localparam int H_ACTIVE    = 640;
  localparam int H_FP        = 16;
  localparam int H_SYNC      = 96;
  localparam int H_BP        = 48;
  localparam int V_ACTIVE    = 480;
  localparam int V_FP        = 10;
  localparam int V_SYNC      = 2;
  localparam int V_BP        = 33;
  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;
  localparam int SCREEN_SIZE = SCREEN_W * SCREEN_H;
  localparam int ADDR_W      = 19;
  localparam int CNT_W       = 10;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  // Bit replication keeps full-scale 0 and 1 at 0x00 and 0xFF
  function automatic rgb888_t rgb332_to_888(input logic [7:0] c);
    return {c[7:5], c[7:5], c[7:6], c[4:2], c[4:2], c[4:3], {4{c[1:0]}}};
  endfunction
endpackage

// File: rtl/vfd_timing.sv
// vfd_timing: raster counters and raw S0 sync/blank/active flags
module vfd_timing
  import vfd_pkg::*;
#(
  parameter int P_H_ACTIVE = H_ACTIVE,
  parameter int P_H_FP     = H_FP,
  parameter int P_H_SYNC   = H_SYNC,
  parameter int P_H_BP     = H_BP,
  parameter int P_V_ACTIVE = V_ACTIVE,
  parameter int P_V_FP     = V_FP,
  parameter int P_V_SYNC   = V_SYNC,
  parameter int P_V_BP     = V_BP
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_ce,
  output logic [CNT_W-1:0] o_hcnt,
  output logic [CNT_W-1:0] o_vcnt,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_hblank,
  output logic             o_vblank,
  output logic             o_active,
  output logic             o_frame_end
);
  localparam logic [CNT_W-1:0] L_H_ACT  = CNT_W'(P_H_ACTIVE);
  localparam logic [CNT_W-1:0] L_HS_ON  = CNT_W'(P_H_ACTIVE + P_H_FP);
  localparam logic [CNT_W-1:0] L_HS_OFF = CNT_W'(P_H_ACTIVE + P_H_FP + P_H_SYNC);
  localparam logic [CNT_W-1:0] L_H_LAST = CNT_W'(P_H_ACTIVE + P_H_FP + P_H_SYNC + P_H_BP - 1);
  localparam logic [CNT_W-1:0] L_V_ACT  = CNT_W'(P_V_ACTIVE);
  localparam logic [CNT_W-1:0] L_VS_ON  = CNT_W'(P_V_ACTIVE + P_V_FP);
  localparam logic [CNT_W-1:0] L_VS_OFF = CNT_W'(P_V_ACTIVE + P_V_FP + P_V_SYNC);
  localparam logic [CNT_W-1:0] L_V_LAST = CNT_W'(P_V_ACTIVE + P_V_FP + P_V_SYNC + P_V_BP - 1);

  logic [CNT_W-1:0] r_hcnt;
  logic [CNT_W-1:0] r_vcnt;
  logic             w_hend;
  logic             w_vend;

  assign w_hend = r_hcnt == L_H_LAST;
  assign w_vend = r_vcnt == L_V_LAST;

  // Pixel counter wraps at end of line; line counter steps on each line wrap
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (i_ce) begin
      r_hcnt <= w_hend ? '0 : r_hcnt + 1'b1;
      if (w_hend) r_vcnt <= w_vend ? '0 : r_vcnt + 1'b1;
    end
  end

  assign o_hcnt      = r_hcnt;
  assign o_vcnt      = r_vcnt;
  assign o_hsync     = (r_hcnt >= L_HS_ON) && (r_hcnt < L_HS_OFF);
  assign o_vsync     = (r_vcnt >= L_VS_ON) && (r_vcnt < L_VS_OFF);
  assign o_hblank    = r_hcnt >= L_H_ACT;
  assign o_vblank    = r_vcnt >= L_V_ACT;
  assign o_active    = (r_hcnt < L_H_ACT) && (r_vcnt < L_V_ACT);
  assign o_frame_end = w_hend && w_vend;
endmodule

// File: rtl/vfd_scanout.sv
// vfd_scanout: 640x480@60 frame buffer scan-out; VFD_SCANLINES_EN dims odd lines
module vfd_scanout
  import vfd_pkg::*;
#(
  parameter int P_H_ACTIVE = H_ACTIVE,
  parameter int P_H_FP     = H_FP,
  parameter int P_H_SYNC   = H_SYNC,
  parameter int P_H_BP     = H_BP,
  parameter int P_V_ACTIVE = V_ACTIVE,
  parameter int P_V_FP     = V_FP,
  parameter int P_V_SYNC   = V_SYNC,
  parameter int P_V_BP     = V_BP
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ce_pix,
  output logic [ADDR_W-1:0] vram_addr,
  input  logic [7:0]        vram_data,
  output logic [7:0]        r,
  output logic [7:0]        g,
  output logic [7:0]        b,
  output logic              hsync,
  output logic              vsync,
  output logic              hblank,
  output logic              vblank,
  output logic              frame_start
);
  logic [CNT_W-1:0]  w_hcnt;
  logic [CNT_W-1:0]  w_vcnt;
  logic              w_hs;
  logic              w_vs;
  logic              w_hb;
  logic              w_vb;
  logic              w_active;
  logic              w_frame_end;
  logic [ADDR_W-1:0] w_addr;
  rgb888_t           w_rgb;
  rgb888_t           w_pix;

  logic              r_armed;
  logic [ADDR_W-1:0] r_addr;
  logic              r_s1_hs;
  logic              r_s1_vs;
  logic              r_s1_hb;
  logic              r_s1_vb;
  logic              r_s1_first;
  logic [7:0]        r_r;
  logic [7:0]        r_g;
  logic [7:0]        r_b;
  logic              r_hs;
  logic              r_vs;
  logic              r_hb;
  logic              r_vb;
  logic              r_fs;

  vfd_timing #(
    .P_H_ACTIVE(P_H_ACTIVE), .P_H_FP(P_H_FP), .P_H_SYNC(P_H_SYNC), .P_H_BP(P_H_BP),
    .P_V_ACTIVE(P_V_ACTIVE), .P_V_FP(P_V_FP), .P_V_SYNC(P_V_SYNC), .P_V_BP(P_V_BP)
  ) u_timing (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_ce       (ce_pix),
    .o_hcnt     (w_hcnt),
    .o_vcnt     (w_vcnt),
    .o_hsync    (w_hs),
    .o_vsync    (w_vs),
    .o_hblank   (w_hb),
    .o_vblank   (w_vb),
    .o_active   (w_active),
    .o_frame_end(w_frame_end)
  );

  // y*640 + x as shifts; only evaluated for visible pixels so it stays below SCREEN_SIZE
  assign w_addr = {w_vcnt, 9'b0} + ADDR_W'({w_vcnt, 7'b0}) + ADDR_W'(w_hcnt);
  assign w_rgb  = rgb332_to_888(vram_data);

`ifdef VFD_SCANLINES_EN
  logic r_s1_odd;

  // Line parity travels with the pixel so dimming lines up with S2
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_s1_odd <= 1'b0;
    else if (ce_pix) r_s1_odd <= w_vcnt[0];
  end

  assign w_pix = r_s1_odd ? {w_rgb.r >> 1, w_rgb.g >> 1, w_rgb.b >> 1} : w_rgb;
`else
  assign w_pix = w_rgb;
`endif

  // The frame running at reset release is run-up; frame_start is armed by its wrap
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_armed <= 1'b0;
    else if (ce_pix && w_frame_end) r_armed <= 1'b1;
  end

  // S1: VRAM address (held through blanking) plus delayed timing flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr     <= '0;
      r_s1_hs    <= 1'b0;
      r_s1_vs    <= 1'b0;
      r_s1_hb    <= 1'b1;
      r_s1_vb    <= 1'b1;
      r_s1_first <= 1'b0;
    end else if (ce_pix) begin
      if (w_active) r_addr <= w_addr;
      r_s1_hs    <= w_hs;
      r_s1_vs    <= w_vs;
      r_s1_hb    <= w_hb;
      r_s1_vb    <= w_vb;
      r_s1_first <= r_armed && (w_hcnt == '0) && (w_vcnt == '0);
    end
  end

  // S2: capture VRAM data, blank the colour, present everything together
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_r  <= '0;
      r_g  <= '0;
      r_b  <= '0;
      r_hs <= 1'b0;
      r_vs <= 1'b0;
      r_hb <= 1'b1;
      r_vb <= 1'b1;
      r_fs <= 1'b0;
    end else begin
      r_fs <= ce_pix && r_s1_first;
      if (ce_pix) begin
        r_r  <= (r_s1_hb || r_s1_vb) ? 8'h00 : w_pix.r;
        r_g  <= (r_s1_hb || r_s1_vb) ? 8'h00 : w_pix.g;
        r_b  <= (r_s1_hb || r_s1_vb) ? 8'h00 : w_pix.b;
        r_hs <= r_s1_hs;
        r_vs <= r_s1_vs;
        r_hb <= r_s1_hb;
        r_vb <= r_s1_vb;
      end
    end
  end

  assign vram_addr   = r_addr;
  assign r           = r_r;
  assign g           = r_g;
  assign b           = r_b;
  assign hsync       = r_hs;
  assign vsync       = r_vs;
  assign hblank      = r_hb;
  assign vblank      = r_vb;
  assign frame_start = r_fs;
endmodule

// File: tb/tb_vfd_scanout.sv
// tb_vfd_scanout: directed checks of scan-out timing, addressing, colour and reset
module tb_vfd_scanout;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce_pix = 1'b0;
  logic [18:0] vram_addr;
  logic [18:0] vram_addr_s;
  logic [7:0]  vram_data = 8'h00;
  logic [7:0]  r, g, b, r_s, g_s, b_s;
  logic        hsync, vsync, hblank, vblank, frame_start;
  logic        hsync_s, vsync_s, hblank_s, vblank_s, frame_start_s;
  logic        ovr_en = 1'b0;
  logic [7:0]  ovr = 8'h00;
  logic [28:0] e_px;
  logic [28:0] e_sm;
  int          checks = 0;
  int          failures = 0;
  int          t = 0;
  int          exp_addr = 0;
  int          pn;

  always #5 clk = ~clk;

  // VRAM model: data valid one clk after the address, optionally overridden
  always @(posedge clk) vram_data <= ovr_en ? ovr : vram_addr[7:0];

  vfd_scanout u_dut (
    .clk(clk), .reset_n(reset_n), .ce_pix(ce_pix), .vram_addr(vram_addr),
    .vram_data(vram_data), .r(r), .g(g), .b(b), .hsync(hsync), .vsync(vsync),
    .hblank(hblank), .vblank(vblank), .frame_start(frame_start)
  );

  // 15x8 raster so whole frames fit in a short run
  vfd_scanout #(
    .P_H_ACTIVE(8), .P_H_FP(2), .P_H_SYNC(3), .P_H_BP(2),
    .P_V_ACTIVE(4), .P_V_FP(1), .P_V_SYNC(2), .P_V_BP(1)
  ) u_small (
    .clk(clk), .reset_n(reset_n), .ce_pix(ce_pix), .vram_addr(vram_addr_s),
    .vram_data(8'h00), .r(r_s), .g(g_s), .b(b_s), .hsync(hsync_s), .vsync(vsync_s),
    .hblank(hblank_s), .vblank(vblank_s), .frame_start(frame_start_s)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] exp_rgb(input logic [7:0] d, input logic dim);
    logic [7:0] er, eg, eb;
    er = {d[7:5], d[7:5], d[7:6]};
    eg = {d[4:2], d[4:2], d[4:3]};
    eb = {d[1:0], d[1:0], d[1:0], d[1:0]};
    return dim ? {er >> 1, eg >> 1, eb >> 1} : {er, eg, eb};
  endfunction

  task automatic tick();
    @(negedge clk) ce_pix = 1'b1;
    @(negedge clk) ce_pix = 1'b0;
  endtask

  task automatic set_reset_exp();
    e_px = {24'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    e_sm = e_px;
    exp_addr = 0;
  endtask

  task automatic check_now(input string tag);
    chk({tag, " px"}, 64'({r, g, b, hsync, vsync, hblank, vblank, frame_start}), 64'(e_px));
    chk({tag, " addr"}, 64'(vram_addr), 64'(exp_addr));
    chk({tag, " small"}, 64'({r_s, g_s, b_s, hsync_s, vsync_s, hblank_s, vblank_s, frame_start_s}), 64'(e_sm));
  endtask

  task automatic step();
    int p, h, v;
    logic [7:0] d;
    logic dim;
    d = ovr_en ? ovr : exp_addr[7:0];
    tick();
    t++;
    if (t >= 2) begin
      p = t - 2;
      h = p % 800;
      v = (p / 800) % 525;
`ifdef VFD_SCANLINES_EN
      dim = (v % 2) == 1;
`else
      dim = 1'b0;
`endif
      e_px = {(h >= 640 || v >= 480) ? 24'h0 : exp_rgb(d, dim),
              h >= 656 && h < 752, v >= 490 && v < 492, h >= 640, v >= 480,
              p >= 420000 && p % 420000 == 0};
      h = p % 15;
      v = (p / 15) % 8;
      e_sm = {24'h0, h >= 10 && h < 13, v >= 5 && v < 7, h >= 8, v >= 4,
              p >= 120 && p % 120 == 0};
    end else begin
      e_px = {24'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      e_sm = e_px;
    end
    p = t - 1;
    h = p % 800;
    v = (p / 800) % 525;
    if (h < 640 && v < 480) exp_addr = v * 640 + h;
    check_now($sformatf("t%0d", t));
  endtask

  initial begin
    set_reset_exp();
    repeat (3) tick();
    check_now("reset");
    @(negedge clk) reset_n = 1'b1;
    t = 0;
    for (int i = 0; i < 1700; i++) begin
      pn = t - 1;
      ovr_en = 1'b1;
      if (pn >= 100 && pn < 104) ovr = 8'hE3;
      else if (pn >= 200 && pn < 204) ovr = 8'h49;
      else if ((pn >= 10 && pn < 14) || (pn >= 810 && pn < 814) || (pn >= 700 && pn < 704)) ovr = 8'hFF;
      else ovr_en = 1'b0;
      step();
      if (t - 2 == 11) chk("rgb_ff_line0", 64'({r, g, b}), 64'(24'hFFFFFF));
      if (t - 2 == 101) chk("rgb_e3", 64'({r, g, b}), 64'(24'hFF00FF));
      if (t - 2 == 201) chk("rgb_49", 64'({r, g, b}), 64'(24'h494955));
      if (t - 2 == 701) chk("rgb_blank", 64'({r, g, b}), 64'(24'h000000));
`ifdef VFD_SCANLINES_EN
      if (t - 2 == 811) chk("rgb_ff_line1", 64'({r, g, b}), 64'(24'h7F7F7F));
`else
      if (t - 2 == 811) chk("rgb_ff_line1", 64'({r, g, b}), 64'(24'hFFFFFF));
`endif
      if (t - 1 == 639) chk("addr_639", 64'(vram_addr), 64'd639);
      if (t - 1 == 800) chk("addr_640", 64'(vram_addr), 64'd640);
      if (t - 1 == 1600) chk("addr_1280", 64'(vram_addr), 64'd1280);
      if (t == 300) begin
        repeat (100) @(negedge clk);
        check_now("stall");
      end
    end
    ovr_en = 1'b0;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 set_reset_exp();
    check_now("async_rst");
    repeat (2) tick();
    check_now("rst_hold");
    @(negedge clk) reset_n = 1'b1;
    t = 0;
    for (int i = 0; i < 260; i++) begin
      step();
      if (t == 122) chk("small_fs_first", 64'(frame_start_s), 64'd1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
